timestamp_capture: RTL

TIMESTAMP_CAPTURE -- requirements
Module: timestamp_capture

---
 rtl/timestamp_capture.sv | 110 +++++++++++
 1 files changed

// File: rtl/timestamp_capture.sv
// Timestamp capture FIFO: synchronises an async event line and queues counter_in snapshots.
// Define TS_DELTA_EN to store the difference from the previously accepted timestamp.
module timestamp_capture #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         counter_in,
    input  logic                     event_in,
    output logic                     ts_valid,
    input  logic                     ts_ready,
    output logic [WIDTH-1:0]         ts_data,
    output logic                     overflow,
    input  logic                     clr_ovf,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("timestamp_capture: DEPTH must be a power of two and at least 2");
    end

    logic              sync1_q, sync2_q, evt_dly_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              ovf_q, ovf_d;
    logic [WIDTH-1:0]  wdata;
    logic              rise, full, push, pop, drop;

    // Handshake: an entry is transferred at a rising clk edge where ts_valid && ts_ready;
    // ts_valid never depends on ts_ready and ts_data holds until that edge.
    assign rise = sync2_q & ~evt_dly_q;
    assign full = (level_q == LW'(DEPTH));
    assign pop  = (level_q != '0) & ts_ready;
    assign push = rise & (~full | pop);
    assign drop = rise & full & ~pop;

`ifdef TS_DELTA_EN
    logic [WIDTH-1:0] last_ts_q;

    assign wdata = counter_in - last_ts_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_ts_q <= '0;
        end else if (push) begin
            last_ts_q <= counter_in;
        end
    end
`else
    assign wdata = counter_in;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // A drop in the same cycle as a clear must leave the flag set.
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            evt_dly_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            sync1_q   <= event_in;
            sync2_q   <= sync1_q;
            evt_dly_q <= sync2_q;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage is cleared on reset so ts_data reads zero while the FIFO is reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign ts_valid = (level_q != '0);
    assign ts_data  = mem_q[rd_ptr_q];
    assign overflow = ovf_q;
    assign level    = level_q;

endmodule
